tx_block: RTL



---
 rtl/tx_block.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/tx_block.sv
// rtl/tx_block.sv - UART-style serial transmitter with one-byte holding buffer; optional even parity via TX_PARITY_EN
module tx_block #(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       load_data,
  input  logic       clear_error,
  output logic       serial_out,
  output logic       buffer_empty,
  output logic       tx_busy,
  output logic       overrun_error
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity, when present, rides above the data byte so it falls out of the
  // same right-shift path after the eighth data bit.
`ifdef TX_PARITY_EN
  localparam int SHIFT_W = 9;
`else
  localparam int SHIFT_W = 8;
`endif

  localparam logic [7:0] LAST_CYC = 8'(BIT_PERIOD - 1);

  logic [2:0]         state_q,     state_d;
  logic [7:0]         cyc_q,       cyc_d;
  logic [2:0]         bit_q,       bit_d;
  logic [SHIFT_W-1:0] shift_q,     shift_d;
  logic               serial_q,    serial_d;
  logic               busy_q,      busy_d;
  logic [7:0]         buf_q,       buf_d;
  logic               buf_empty_q, buf_empty_d;
  logic               ovr_q,       ovr_d;

  logic               bit_end;
  logic               transfer;
  logic [SHIFT_W-1:0] shift_load;

  assign bit_end = (cyc_q == LAST_CYC);

`ifdef TX_PARITY_EN
  assign shift_load = {^buf_q, buf_q};
`else
  assign shift_load = buf_q;
`endif

  // Next-state logic: sequencing, counters, and the value the line takes after this edge
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    transfer = 1'b0;

    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        if (!buf_empty_q) begin
          transfer = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d  = ST_DATA;
          cyc_d    = 8'd0;
          bit_d    = 3'd0;
          serial_d = shift_q[0];
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          cyc_d   = 8'd0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
            state_d  = ST_PARITY;
            serial_d = shift_q[1];
`else
            state_d  = ST_STOP;
            serial_d = 1'b1;
`endif
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = shift_q[1];
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end

`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d  = ST_STOP;
          cyc_d    = 8'd0;
          serial_d = 1'b1;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
`endif

      ST_STOP: begin
        if (bit_end) begin
          cyc_d = 8'd0;
          if (!buf_empty_q) begin
            transfer = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            serial_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cyc_d    = 8'd0;
        bit_d    = 3'd0;
        serial_d = 1'b1;
      end
    endcase

    // A transfer always launches a fresh start bit, from IDLE or straight out of STOP
    if (transfer) begin
      state_d  = ST_START;
      cyc_d    = 8'd0;
      bit_d    = 3'd0;
      shift_d  = shift_load;
      serial_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Holding buffer and sticky overrun flag; a write and a transfer can never
  // coincide because one needs the buffer empty and the other needs it full
  always_comb begin
    buf_d       = buf_q;
    buf_empty_d = buf_empty_q;
    ovr_d       = ovr_q;

    if (transfer) begin
      buf_empty_d = 1'b1;
    end

    if (load_data && buf_empty_q) begin
      buf_d       = tx_data;
      buf_empty_d = 1'b0;
    end

    if (clear_error) begin
      ovr_d = 1'b0;
    end
    if (load_data && !buf_empty_q) begin
      ovr_d = 1'b1;
    end
  end

  // Transmit FSM, counters, shift register and registered line driver
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cyc_q    <= 8'd0;
      bit_q    <= 3'd0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
    end
  end

  // Holding buffer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q       <= 8'd0;
      buf_empty_q <= 1'b1;
      ovr_q       <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      buf_empty_q <= buf_empty_d;
      ovr_q       <= ovr_d;
    end
  end

  assign serial_out    = serial_q;
  assign buffer_empty  = buf_empty_q;
  assign tx_busy       = busy_q;
  assign overrun_error = ovr_q;

endmodule
